// File: rtl/beagleg_pkg.sv
// Shared types for the motion segment dispatcher.
//   motion_segment_t   : one per-axis segment as consumed by a step generator
//   dispatcher_state_e : segment_dispatcher FSM states
//   axis_mask_t        : axis enable mask at the default axis count
//   motion_bundle_t    : mask plus one segment per axis
package beagleg_pkg;

  localparam int DEFAULT_NUM_AXES = 4;

  typedef struct packed {
    logic [31:0] target_steps;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        direction;
  } motion_segment_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } dispatcher_state_e;

  typedef logic [DEFAULT_NUM_AXES-1:0] axis_mask_t;

  typedef struct packed {
    axis_mask_t                                mask;
    motion_segment_t [DEFAULT_NUM_AXES-1:0]    seg;
  } motion_bundle_t;

endpackage

// File: rtl/segment_dispatcher_axis_issue_tracker.sv
// Per-axis issue tracking for segment_dispatcher.
//   clk, rst        : clock, async active-high reset
//   data_request    : generator data_request level
//   issue           : dispatcher is in ISSUE
//   mask_bit        : this axis takes part in the current bundle
//   clear_ack       : drop the sticky ack
//   ack_next        : ack value for the next cycle (includes this cycle's edge)
//   data_available  : to generator data_available
module axis_issue_tracker (
  input  logic clk,
  input  logic rst,
  input  logic data_request,
  input  logic issue,
  input  logic mask_bit,
  input  logic clear_ack,
  output logic ack_next,
  output logic data_available
);

  logic req_prev_q, req_prev_d;
  logic ack_q, ack_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      req_prev_q <= req_prev_d;
      ack_q      <= ack_d;
    end
  end

  // Only a fresh 0->1 edge acks, so a request level left over from the
  // previous segment cannot be mistaken for taking the new one.
  always_comb begin
    req_prev_d = data_request;
    ack_d      = ack_q;
    if (clear_ack) begin
      ack_d = 1'b0;
    end else if (issue && mask_bit && data_request && !req_prev_q) begin
      ack_d = 1'b1;
    end
  end

  assign ack_next       = ack_d;
  assign data_available = issue && mask_bit && !ack_q;

endmodule

// File: rtl/segment_dispatcher.sv
// Lock-step dispatcher of multi-axis motion bundles into step generators.
//   clk, rst                : clock, async active-high reset
//   in_valid/in_ready       : upstream bundle handshake
//   in_mask, in_seg         : bundle axis mask and per-axis segments
//   axis_data_available     : per-axis data_available to generators
//   axis_data               : per-axis segment to generators
//   axis_data_request       : per-axis data_request from generators
//   axis_is_busy            : per-axis is_busy from generators
//   abort                   : discard the pending issue (level)
//   clear_fault             : leave FAULT
//   busy, fault             : status
//   seg_done, segments_done : completion pulse and wrapping count
//
// state    | meaning
// IDLE     | ready for a bundle
// ISSUE    | offering segments until every enabled axis acks
// RUN      | waiting for the taking axes to go idle
// FAULT    | ack timeout; waits for clear_fault
module segment_dispatcher
  import beagleg_pkg::*;
#(
  parameter int NUM_AXES    = 4,
  parameter int ACK_TIMEOUT = 1023,
  parameter int COUNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_AXES-1:0]            in_mask,
  input  motion_segment_t [NUM_AXES-1:0] in_seg,
  output logic [NUM_AXES-1:0]            axis_data_available,
  output motion_segment_t [NUM_AXES-1:0] axis_data,
  input  logic [NUM_AXES-1:0]            axis_data_request,
  input  logic [NUM_AXES-1:0]            axis_is_busy,
  input  logic                           abort,
  input  logic                           clear_fault,
  output logic                           busy,
  output logic                           fault,
  output logic                           seg_done,
  output logic [COUNT_W-1:0]             segments_done
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  dispatcher_state_e               state_q, state_d;
  logic [NUM_AXES-1:0]             mask_q, mask_d;
  motion_segment_t [NUM_AXES-1:0]  axis_data_q, axis_data_d;
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic                            aborted_q, aborted_d;
  logic                            seg_done_q, seg_done_d;
  logic [COUNT_W-1:0]              count_q, count_d;
  logic                            rst_done_q, rst_done_d;

  logic [NUM_AXES-1:0]             ack_next;
  logic [TMO_W-1:0]                tmo_inc;
  logic                            issue;
  logic                            clear_ack;
  logic                            accept;
  logic                            all_acked;
  logic                            axes_idle;
  logic                            timed_out;

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    axis_issue_tracker u_trk (
      .clk            (clk),
      .rst            (rst),
      .data_request   (axis_data_request[i]),
      .issue          (issue),
      .mask_bit       (mask_q[i]),
      .clear_ack      (clear_ack),
      .ack_next       (ack_next[i]),
      .data_available (axis_data_available[i])
    );
  end

  assign tmo_inc   = tmo_q + 1'b1;
  assign timed_out = (tmo_inc == TMO_W'(ACK_TIMEOUT));
  assign all_acked = ((ack_next & mask_q) == mask_q);
  assign axes_idle = ((axis_is_busy & mask_q) == '0);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      axis_data_q <= '0;
      tmo_q       <= '0;
      aborted_q   <= 1'b0;
      seg_done_q  <= 1'b0;
      count_q     <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      axis_data_q <= axis_data_d;
      tmo_q       <= tmo_d;
      aborted_q   <= aborted_d;
      seg_done_q  <= seg_done_d;
      count_q     <= count_d;
      rst_done_q  <= rst_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    axis_data_d = axis_data_q;
    tmo_d       = tmo_q;
    aborted_d   = aborted_q;
    seg_done_d  = 1'b0;
    count_d     = count_q;
    rst_done_d  = 1'b1;
    clear_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          axis_data_d = in_seg;
          mask_d      = in_mask;
          if (in_mask == '0) begin
            seg_done_d = 1'b1;
            count_d    = count_q + 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmo_d = tmo_inc;
        // A full ack beats both abort and timeout in the same cycle: every
        // axis has the segment, so the bundle completes normally.
        if (all_acked) begin
          state_d = ST_RUN;
          tmo_d   = '0;
        end else if (abort) begin
          // Only axes that already took their segment are waited on.
          state_d   = ST_RUN;
          mask_d    = mask_q & ack_next;
          aborted_d = 1'b1;
          tmo_d     = '0;
        end else if (timed_out) begin
          state_d = ST_FAULT;
        end
      end
      ST_RUN: begin
        if (axes_idle) begin
          state_d   = ST_IDLE;
          clear_ack = 1'b1;
          aborted_d = 1'b0;
          if (!aborted_q) begin
            seg_done_d = 1'b1;
            count_d    = count_q + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d   = ST_IDLE;
          clear_ack = 1'b1;
          tmo_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue         = (state_q == ST_ISSUE);
    in_ready      = rst_done_q && (state_q == ST_IDLE) && !abort;
    busy          = (state_q != ST_IDLE);
    fault         = (state_q == ST_FAULT);
    seg_done      = seg_done_q;
    segments_done = count_q;
    axis_data     = axis_data_q;
  end

endmodule

// File: tb/tb_segment_dispatcher.sv
module tb_segment_dispatcher;
  import beagleg_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_mask;
  motion_segment_t [3:0]  in_seg;
  logic [3:0]             axis_data_available;
  motion_segment_t [3:0]  axis_data;
  logic [3:0]             axis_data_request;
  logic [3:0]             axis_is_busy;
  logic                   abort;
  logic                   clear_fault;
  logic                   busy;
  logic                   fault;
  logic                   seg_done;
  logic [3:0]             segments_done;

  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_done = 4'd0;

  segment_dispatcher #(
    .NUM_AXES    (4),
    .ACK_TIMEOUT (16),
    .COUNT_W     (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_mask             (in_mask),
    .in_seg              (in_seg),
    .axis_data_available (axis_data_available),
    .axis_data           (axis_data),
    .axis_data_request   (axis_data_request),
    .axis_is_busy        (axis_is_busy),
    .abort               (abort),
    .clear_fault         (clear_fault),
    .busy                (busy),
    .fault               (fault),
    .seg_done            (seg_done),
    .segments_done       (segments_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_mask = 4'b0000;
    in_seg = '0;
    axis_data_request = 4'b0000;
    axis_is_busy = 4'b0000;
    abort = 1'b0;
    clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || seg_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_status got ready=%b busy=%b fault=%b done=%b exp 0 0 0 0",
               in_ready, busy, fault, seg_done);
    end
    total++;
    if (axis_data_available !== 4'b0000 || segments_done !== 4'd0 || axis_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs got avail=%b count=%0d exp avail=0000 count=0",
               axis_data_available, segments_done);
    end
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_two_axis();
    in_seg = '0;
    in_seg[0].target_steps = 32'd10;
    in_seg[1].target_steps = 32'd20;
    in_mask = 4'b0011;
    in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL two_axis_ready0 got=%b exp=1", in_ready);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      axis_data_request[0] = (c == 2);
      axis_data_request[1] = (c == 5);
      axis_is_busy[0] = (c >= 2 && c <= 7);
      axis_is_busy[1] = (c >= 5 && c <= 9);
      #1;
      if (c == 1) begin
        total++;
        if (axis_data_available !== 4'b0011 || in_ready !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL two_axis_issue got avail=%b ready=%b busy=%b exp 0011 0 1",
                   axis_data_available, in_ready, busy);
        end
        total++;
        if (axis_data[0].target_steps !== 32'd10 || axis_data[1].target_steps !== 32'd20) begin
          bad++;
          $display("FAIL two_axis_data got %0d/%0d exp 10/20",
                   axis_data[0].target_steps, axis_data[1].target_steps);
        end
      end
      if (c == 2 || c == 3 || c == 5) begin
        total++;
        if (axis_data_available !== ((c == 2) ? 4'b0011 : 4'b0010)) begin
          bad++;
          $display("FAIL two_axis_avail_c%0d got=%b exp=%b", c, axis_data_available,
                   (c == 2) ? 4'b0011 : 4'b0010);
        end
      end
      if (c == 6 || c == 10) begin
        total++;
        if (axis_data_available !== 4'b0000 || in_ready !== 1'b0 || seg_done !== 1'b0 ||
            busy !== 1'b1) begin
          bad++;
          $display("FAIL two_axis_run_c%0d got avail=%b ready=%b done=%b busy=%b exp 0000 0 0 1",
                   c, axis_data_available, in_ready, seg_done, busy);
        end
      end
      if (c == 11) begin
        exp_done++;
        total++;
        if (seg_done !== 1'b1 || segments_done !== exp_done || in_ready !== 1'b1 ||
            busy !== 1'b0) begin
          bad++;
          $display("FAIL two_axis_done got done=%b count=%0d ready=%b busy=%b exp 1 %0d 1 0",
                   seg_done, segments_done, in_ready, busy, exp_done);
        end
      end
      if (c == 12) begin
        total++;
        if (seg_done !== 1'b0) begin
          bad++;
          $display("FAIL two_axis_pulse_width got=%b exp=0", seg_done);
        end
      end
    end
  endtask

  task automatic test_empty_bundle();
    in_mask = 4'b0000;
    in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL empty_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp_done++;
    #1;
    total++;
    if (seg_done !== 1'b1 || segments_done !== exp_done || busy !== 1'b0 ||
        axis_data_available !== 4'b0000 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL empty_done got done=%b count=%0d busy=%b avail=%b ready=%b exp 1 %0d 0 0000 1",
               seg_done, segments_done, busy, axis_data_available, in_ready, exp_done);
    end
    tick();
    #1;
    total++;
    if (seg_done !== 1'b0) begin
      bad++;
      $display("FAIL empty_pulse_width got=%b exp=0", seg_done);
    end
  endtask

  task automatic test_timeout();
    in_mask = 4'b0111;
    in_valid = 1'b1;
    #1;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      axis_data_request = (c == 2) ? 4'b0011 : 4'b0000;
      axis_is_busy = (c >= 2 && c <= 5) ? 4'b0011 : 4'b0000;
      clear_fault = (c == 18);
      #1;
      if (c == 16) begin
        total++;
        if (fault !== 1'b0 || axis_data_available !== 4'b0100) begin
          bad++;
          $display("FAIL timeout_before got fault=%b avail=%b exp 0 0100", fault, axis_data_available);
        end
      end
      if (c == 17) begin
        total++;
        if (fault !== 1'b1 || axis_data_available !== 4'b0000 || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL timeout_fault got fault=%b avail=%b ready=%b exp 1 0000 0",
                   fault, axis_data_available, in_ready);
        end
      end
      if (c == 19) begin
        total++;
        if (fault !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || seg_done !== 1'b0 ||
            segments_done !== exp_done) begin
          bad++;
          $display("FAIL timeout_clear got fault=%b ready=%b busy=%b done=%b count=%0d exp 0 1 0 0 %0d",
                   fault, in_ready, busy, seg_done, segments_done, exp_done);
        end
      end
    end
  endtask

  task automatic test_stale_request();
    axis_data_request = 4'b0001;
    tick();
    in_seg = '0;
    in_seg[0].target_steps = 32'd7;
    in_mask = 4'b0001;
    in_valid = 1'b1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      axis_data_request = (c == 4) ? 4'b0000 : 4'b0001;
      axis_is_busy = (c >= 5 && c <= 6) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 2 || c == 4 || c == 5) begin
        total++;
        if (axis_data_available !== 4'b0001) begin
          bad++;
          $display("FAIL stale_no_ack_c%0d got=%b exp=0001", c, axis_data_available);
        end
      end
      if (c == 6 || c == 7) begin
        total++;
        if (axis_data_available !== 4'b0000 || busy !== 1'b1) begin
          bad++;
          $display("FAIL stale_run_c%0d got avail=%b busy=%b exp 0000 1", c, axis_data_available, busy);
        end
      end
      if (c == 8) begin
        exp_done++;
        total++;
        if (seg_done !== 1'b1 || segments_done !== exp_done || busy !== 1'b0) begin
          bad++;
          $display("FAIL stale_done got done=%b count=%0d busy=%b exp 1 %0d 0",
                   seg_done, segments_done, busy, exp_done);
        end
      end
    end
    axis_data_request = 4'b0000;
  endtask

  task automatic test_abort();
    in_mask = 4'b0011;
    in_valid = 1'b1;
    #1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      axis_data_request = (c == 2) ? 4'b0001 : 4'b0000;
      axis_is_busy = ((c >= 2 && c <= 6) ? 4'b0001 : 4'b0000) | 4'b0010;
      abort = (c == 3);
      #1;
      if (c == 3) begin
        total++;
        if (axis_data_available !== 4'b0010 || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL abort_issue got avail=%b ready=%b exp 0010 0", axis_data_available, in_ready);
        end
      end
      if (c == 4 || c == 7) begin
        total++;
        if (axis_data_available !== 4'b0000 || busy !== 1'b1) begin
          bad++;
          $display("FAIL abort_run_c%0d got avail=%b busy=%b exp 0000 1", c, axis_data_available, busy);
        end
      end
      if (c == 8 || c == 9) begin
        total++;
        if (busy !== 1'b0 || seg_done !== 1'b0 || segments_done !== exp_done || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL abort_end_c%0d got busy=%b done=%b count=%0d ready=%b exp 0 0 %0d 1",
                   c, busy, seg_done, segments_done, in_ready, exp_done);
        end
      end
    end
    tick();
    axis_is_busy = 4'b0000;
    abort = 1'b1;
    in_mask = 4'b0001;
    in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle_ready got=%b exp=0", in_ready);
    end
    tick();
    #1;
    total++;
    if (busy !== 1'b0 || axis_data_available !== 4'b0000 || seg_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle_blocked got busy=%b avail=%b done=%b exp 0 0000 0",
               busy, axis_data_available, seg_done);
    end
    abort = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_count_wrap();
    in_mask = 4'b0000;
    while (exp_done != 4'd15) begin
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_done++;
    end
    #1;
    total++;
    if (segments_done !== 4'd15) begin
      bad++;
      $display("FAIL wrap_pre got=%0d exp=15", segments_done);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_done++;
      #1;
      total++;
      if (segments_done !== exp_done || seg_done !== 1'b1) begin
        bad++;
        $display("FAIL wrap_k%0d got count=%0d done=%b exp %0d 1", k, segments_done, seg_done, exp_done);
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    in_seg = '0;
    in_seg[0].target_steps = 32'd3;
    in_mask = 4'b0001;
    in_valid = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      axis_data_request = (c == 2) ? 4'b0001 : 4'b0000;
      axis_is_busy = (c >= 2) ? 4'b0001 : 4'b0000;
      #1;
    end
    total++;
    if (busy !== 1'b1 || axis_data_available !== 4'b0000 || axis_data[0].target_steps !== 32'd3) begin
      bad++;
      $display("FAIL rst_pre_run got busy=%b avail=%b steps=%0d exp 1 0000 3",
               busy, axis_data_available, axis_data[0].target_steps);
    end
    rst = 1'b1;
    #1;
    exp_done = 4'd0;
    total++;
    if (busy !== 1'b0 || fault !== 1'b0 || seg_done !== 1'b0 || in_ready !== 1'b0 ||
        axis_data_available !== 4'b0000 || segments_done !== 4'd0 || axis_data !== '0) begin
      bad++;
      $display("FAIL rst_mid_run got busy=%b fault=%b done=%b ready=%b avail=%b count=%0d exp all 0",
               busy, fault, seg_done, in_ready, axis_data_available, segments_done);
    end
    axis_is_busy = 4'b0000;
    axis_data_request = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_recover got ready=%b busy=%b exp 1 0", in_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_two_axis();
    tick();
    test_empty_bundle();
    tick();
    test_timeout();
    tick();
    test_stale_request();
    tick();
    test_abort();
    tick();
    test_count_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segment_dispatcher.md
Name: segment_dispatcher

Overview:
- Sequences multi-axis motion segments from the upstream segment FIFO into NUM_AXES segment_step_generator instances.
- Issues one bundle (one beagleg_pkg::motion_segment_t per axis, plus an axis enable mask) to all enabled axes together.
- Waits until every enabled axis has taken its segment and gone idle before accepting the next bundle, so axes stay in lock-step per segment.
- Also provides abort, acknowledge timeout/fault and a completed-segment count.

Parameters:
- NUM_AXES, 4, number of step generators driven (1..8).
- ACK_TIMEOUT, 1023, clk cycles allowed in ISSUE before fault.
- COUNT_W, 16, width of segments_done counter.

Ports:
- clk  in  1  system clock; generators run in this domain.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_mask  in  NUM_AXES  axis enable bits of the bundle.
- in_seg  in  NUM_AXES x motion_segment_t  per-axis segments.
- axis_data_available  out  NUM_AXES  to generator data_available.
- axis_data  out  NUM_AXES x motion_segment_t  to generator data.
- axis_data_request  in  NUM_AXES  from generator data_request.
- axis_is_busy  in  NUM_AXES  from generator is_busy.
- abort  in  1  discard pending issue; level-sensitive.
- clear_fault  in  1  leave FAULT.
- busy  out  1  state != IDLE.
- fault  out  1  high in FAULT.
- seg_done  out  1  one-cycle pulse per completed bundle.
- segments_done  out  COUNT_W  completed bundles, wraps modulo 2^COUNT_W.

Behaviour:
- Reset values: state=IDLE, in_ready=0 during rst then 1, axis_data_available=0, axis_data=0, busy=0, fault=0, seg_done=0, segments_done=0, ack bits=0, timeout counter=0, request edge registers=0. rst mid-operation returns to IDLE immediately; generators are not reset by this block.
- States: IDLE, ISSUE, RUN, FAULT.
- in_ready = (state==IDLE) && !abort.
- IDLE: on accept, register in_seg into axis_data and in_mask into the mask register.
  - mask==0: stay in IDLE; seg_done pulses next cycle; count increments.
  - Otherwise go to ISSUE next cycle.
- ISSUE:
  - axis_data_available[i] = mask[i] && !ack[i].
  - ack[i] sets on the rising edge of axis_data_request[i] (registered previous value, updated every cycle in all states). A level left high from a previous segment never acks.
  - The same cycle ack[i] is set, axis_data_available[i] drops the next cycle.
  - When (ack & mask)==mask, go to RUN and clear the timeout counter.
  - The timeout counter increments each ISSUE cycle. On reaching ACK_TIMEOUT, go to FAULT and drop all axis_data_available.
- RUN: when (axis_is_busy & mask)==0, seg_done pulses for 1 cycle, segments_done increments, ack clears, and the state goes to IDLE. Minimum RUN dwell is 1 cycle.
- FAULT: fault=1 and in_ready=0. On clear_fault, go to IDLE, clear ack, clear the counter.
- abort:
  - In ISSUE: drop all axis_data_available next cycle; go to RUN, waiting only on axes already acked (mask &= ack); no seg_done pulse or count for an aborted bundle.
  - In RUN: no effect.
  - In IDLE: blocks acceptance.
  - abort and ack in the same cycle: the ack counts toward the RUN wait set.
- Simultaneous timeout and full ack in the same cycle: full ack wins (go to RUN).
- Throughput: one bundle per max(generator run) + 3 cycles minimum.

Decomposition:
- beagleg_pkg gains:
  - dispatcher_state_e enum.
  - axis_mask_t (logic [NUM_AXES-1:0]) typedef.
  - motion_bundle_t struct (mask + motion_segment_t array).
- One sub-module, axis_issue_tracker: per-axis rising-edge detect on data_request, sticky ack bit, data_available gating.
- Instantiate NUM_AXES times via generate.

Test Plan:
- Mask=4'b0011, segments with target_steps=10/20; generator models ack 2 and 5 cycles after data_available -> available drops per axis after its ack, RUN entered after the second ack, seg_done once, segments_done=1, in_ready low until both idle.
- Mask=4'b0000 accepted -> no axis_data_available, seg_done pulse 1 cycle later, segments_done increments, state stays IDLE.
- Axis 2 never requests, ACK_TIMEOUT=16 -> fault rises after 16 ISSUE cycles, all available=0, in_ready=0; clear_fault -> IDLE, in_ready=1.
- Axis 0 holds data_request high from the previous segment -> no ack until a fresh 0->1 edge; RUN not entered early.
- abort asserted in ISSUE with axis 0 acked, axis 1 not -> axis 1 available drops, waits for axis 0 idle only, no seg_done, segments_done unchanged.
- segments_done preset near wrap (COUNT_W=4, 16 bundles) -> reads 0 after 16th, then 1; async rst asserted in RUN -> all outputs at reset values within the same cycle.
